alu_multicycle: RTL and testbench
=================================

Name: alu_multicycle

Overview:
- Parametrised, registered successor of the single-cycle ALU, for the multicycle datapath.
- Executes ARM-style ADD/SUB/AND/ORR/EOR in one clock.
- Executes MUL, UDIV and UREM iteratively over WIDTH clocks: shift-add multiplier, restoring divider.
- Uses a start/busy/done handshake; results and NZCV flags are registered and held until the next completion.

Parameters:
- WIDTH, 32: operand and result width in bits; legal range 4..64.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request an operation; sampled only while idle (busy=0).
- a  input  WIDTH  operand A; captured on an accepted start.
- b  input  WIDTH  operand B; captured on an accepted start.
- ALUControl  input  3  opcode: 000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR, 101 MUL, 110 UDIV, 111 UREM.
- Result  output  WIDTH  registered result; held between completions.
- ALUFlags  output  4  registered {N,Z,C,V}; held between completions.
- busy  output  1  high while an iterative operation is in progress.
- done  output  1  one-cycle pulse; Result/ALUFlags updated in this cycle.

Behaviour:
- Reset (asynchronous, active-high): Result=0, ALUFlags=0, busy=0, done=0, iteration counter=0, state=IDLE.
- Reset mid-operation aborts the operation immediately; no done pulse is produced and no partial result appears.
- States: IDLE, ITER.
- Accepted start: start=1 and state=IDLE. start while busy=1 is ignored (not queued).
- Single-cycle ops (000-100), start accepted at edge t:
  - Result/ALUFlags update at t+1; done=1 for that cycle only; state stays IDLE.
  - Back-to-back starts are accepted every cycle.
- Iterative ops (101-111), start accepted at edge t:
  - a, b and opcode are latched; state goes to ITER; counter loads WIDTH.
  - busy=1 for exactly WIDTH cycles, t+1 .. t+WIDTH; the counter decrements once per cycle.
  - On the final iteration: Result/ALUFlags are written, state returns to IDLE, busy=0, done=1 at t+WIDTH+1.
  - A start presented in the done cycle is accepted.
- ADD/SUB:
  - Sum is computed at WIDTH+1 bits as a + (SUB ? ~b : b) + SUB.
  - C = bit WIDTH of the sum (for SUB, C=1 means no borrow).
  - V = signed overflow: operand MSBs equal after the conditional inversion, and the result MSB differs from a's MSB.
- AND/ORR/EOR: C=0, V=0.
- MUL:
  - Unsigned; Result = low WIDTH bits of a*b.
  - Multiplier processes one b bit per iteration, LSB first.
  - C=0, V=0.
- UDIV/UREM:
  - Unsigned restoring division, one quotient bit per iteration, MSB first.
  - UDIV returns the quotient; UREM returns the remainder.
  - C=0, V=0.
- Divide by zero (b=0): still takes the full WIDTH cycles.
  - UDIV: Result = all ones, V=1.
  - UREM: Result = a, V=1.
- All ops: N = Result[WIDTH-1]; Z = (Result == 0).
- Between done pulses, Result/ALUFlags hold their values regardless of input changes.
- Operand inputs may change freely while busy; the latched copies are used.

Test Plan:
- ADD a=0x7FFFFFFF, b=0x00000001, start at t:
  - -> done at t+1, Result=0x80000000, ALUFlags=4'b1001.
  - Result holds at t+2 with start=0.
- SUB a=5, b=5, immediately followed next cycle by ORR a=0xF0, b=0x0F:
  - -> Result=0, ALUFlags=4'b0110.
  - Then the next cycle Result=0xFF, ALUFlags=4'b0000.
- MUL a=0x00010000, b=0x00010001:
  - -> busy high for 32 cycles, done at t+33.
  - Result=0x00010000, ALUFlags=4'b0000.
- UDIV a=100, b=7:
  - -> Result=14, ALUFlags=4'b0000.
  - An ADD start asserted at t+5 is ignored; Result is unchanged until done.
  - Then UREM a=100, b=7 -> Result=2.
- UDIV a=0x1234, b=0:
  - -> done at t+33, Result=0xFFFFFFFF, ALUFlags=4'b1001.
  - UREM a=0x1234, b=0 -> Result=0x00001234, ALUFlags=4'b0001.
- MUL started, reset pulsed at iteration 10:
  - -> busy, done, Result and ALUFlags all 0 without waiting for a clock edge.
  - A subsequent ADD 2+3 completes normally with Result=5.
  - Repeat the MUL, UDIV and reset scenarios with WIDTH=8 (MUL 0x10*0x11 -> 0x10, 8-cycle busy).

Source files
------------

// File: rtl/alu_multicycle.sv
// Registered ALU: ADD/SUB/AND/ORR/EOR in one clock,
// MUL/UDIV/UREM iteratively over WIDTH clocks.
module alu_multicycle #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ALUControl,
    output logic [WIDTH-1:0] Result,
    output logic [3:0]       ALUFlags,
    output logic             busy,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_ORR  = 3'b011;
    localparam logic [2:0] OP_EOR  = 3'b100;
    localparam logic [2:0] OP_MUL  = 3'b101;
    localparam logic [2:0] OP_UDIV = 3'b110;
    localparam logic [2:0] OP_UREM = 3'b111;

    typedef enum logic {
        IDLE,
        ITER
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [3:0]       flags_q, flags_d;
    logic             done_q, done_d;

    logic             is_sub;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] mul_acc;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   rem_diff;
    logic             rem_ge;
    logic [WIDTH-1:0] rem_new;
    logic [WIDTH-1:0] quo_new;
    logic [WIDTH-1:0] new_res;
    logic             new_c;
    logic             new_v;
    logic             wr;

    always_comb begin
        is_sub = (ALUControl == OP_SUB);
        b_eff  = is_sub ? ~b : b;
        sum    = {1'b0, a} + {1'b0, b_eff} + (WIDTH+1)'(is_sub);

        // x_q: multiplicand (MUL) or dividend shifting into quotient (DIV)
        // y_q: multiplier (MUL) or divisor (DIV); acc_q: product or remainder
        mul_acc  = acc_q + (y_q[0] ? x_q : '0);
        rem_sh   = {acc_q, x_q[WIDTH-1]};
        rem_diff = rem_sh - {1'b0, y_q};
        rem_ge   = ~rem_diff[WIDTH];
        rem_new  = rem_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_new  = {x_q[WIDTH-2:0], rem_ge};
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        x_d     = x_q;
        y_d     = y_q;
        acc_d   = acc_q;
        res_d   = res_q;
        flags_d = flags_q;
        done_d  = 1'b0;
        new_res = '0;
        new_c   = 1'b0;
        new_v   = 1'b0;
        wr      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (ALUControl >= OP_MUL) begin
                        state_d = ITER;
                        cnt_d   = CW'(WIDTH);
                        op_d    = ALUControl;
                        x_d     = a;
                        y_d     = b;
                        acc_d   = '0;
                    end else begin
                        wr = 1'b1;
                        unique case (ALUControl)
                            OP_ADD, OP_SUB: begin
                                new_res = sum[WIDTH-1:0];
                                new_c   = sum[WIDTH];
                                new_v   = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
                                          (sum[WIDTH-1] != a[WIDTH-1]);
                            end
                            OP_AND:  new_res = a & b;
                            OP_ORR:  new_res = a | b;
                            OP_EOR:  new_res = a ^ b;
                            default: new_res = '0;
                        endcase
                    end
                end
            end
            ITER: begin
                cnt_d = cnt_q - CW'(1);
                if (op_q == OP_MUL) begin
                    acc_d = mul_acc;
                    x_d   = x_q << 1;
                    y_d   = y_q >> 1;
                end else begin
                    acc_d = rem_new;
                    x_d   = quo_new;
                end
                if (cnt_q == CW'(1)) begin
                    state_d = IDLE;
                    wr      = 1'b1;
                    unique case (op_q)
                        OP_MUL:  new_res = mul_acc;
                        OP_UDIV: new_res = quo_new;
                        OP_UREM: new_res = rem_new;
                        default: new_res = '0;
                    endcase
                    // Restoring division already yields all-ones / a on b=0
                    new_v = (op_q != OP_MUL) && (y_q == '0);
                end
            end
            default: state_d = IDLE;
        endcase

        if (wr) begin
            res_d   = new_res;
            flags_d = {new_res[WIDTH-1], (new_res == '0), new_c, new_v};
            done_d  = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            x_q     <= '0;
            y_q     <= '0;
            acc_q   <= '0;
            res_q   <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            x_q     <= x_d;
            y_q     <= y_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
            flags_q <= flags_d;
            done_q  <= done_d;
        end
    end

    assign Result   = res_q;
    assign ALUFlags = flags_q;
    assign busy     = (state_q == ITER);
    assign done     = done_q;

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed bench for alu_multicycle at WIDTH=32 and WIDTH=8.
// Inputs driven and outputs sampled at the falling edge.
module tb_alu_multicycle;

    logic        clk;
    logic        reset;
    logic        start32;
    logic        start8;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [2:0]  op_in;

    logic [31:0] res32;
    logic [3:0]  flags32;
    logic        busy32;
    logic        done32;
    logic [7:0]  res8;
    logic [3:0]  flags8;
    logic        busy8;
    logic        done8;

    int checks;
    int failures;
    bit sel8;
    int n;

    alu_multicycle #(.WIDTH(32)) dut32 (
        .clk        (clk),
        .reset      (reset),
        .start      (start32),
        .a          (a_in),
        .b          (b_in),
        .ALUControl (op_in),
        .Result     (res32),
        .ALUFlags   (flags32),
        .busy       (busy32),
        .done       (done32)
    );

    alu_multicycle #(.WIDTH(8)) dut8 (
        .clk        (clk),
        .reset      (reset),
        .start      (start8),
        .a          (a_in[7:0]),
        .b          (b_in[7:0]),
        .ALUControl (op_in),
        .Result     (res8),
        .ALUFlags   (flags8),
        .busy       (busy8),
        .done       (done8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] cur_res();
        return sel8 ? {24'h0, res8} : res32;
    endfunction

    function automatic logic [3:0] cur_flags();
        return sel8 ? flags8 : flags32;
    endfunction

    function automatic logic cur_busy();
        return sel8 ? busy8 : busy32;
    endfunction

    function automatic logic cur_done();
        return sel8 ? done8 : done32;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic go(input logic [2:0] op, input logic [31:0] av,
                      input logic [31:0] bv);
        op_in = op;
        a_in  = av;
        b_in  = bv;
        if (sel8) start8 = 1'b1;
        else start32 = 1'b1;
    endtask

    task automatic one(input logic [2:0] op, input logic [31:0] av,
                       input logic [31:0] bv);
        go(op, av, bv);
        step();
        start32 = 1'b0;
        start8  = 1'b0;
    endtask

    // Leaves the bench in the done cycle; nc = busy cycles seen
    task automatic run_iter(input logic [2:0] op, input logic [31:0] av,
                            input logic [31:0] bv, output int nc);
        one(op, av, bv);
        nc = 0;
        while (cur_busy() && nc < 200) begin
            step();
            nc++;
        end
    endtask

    task automatic reset_mid_mul(input int iters, input logic [31:0] av,
                                 input logic [31:0] bv);
        int k;
        one(3'b101, av, bv);
        k = 1;
        while (k < iters) begin
            step();
            k++;
        end
        chk("rst_pre_busy", cur_busy(), 1'b1);
        #2 reset = 1'b1;
        #1;
        chk("rst_busy", cur_busy(), 1'b0);
        chk("rst_done", cur_done(), 1'b0);
        chk("rst_res", cur_res(), 32'h0);
        chk("rst_flags", cur_flags(), 4'h0);
        @(negedge clk);
        reset = 1'b0;
        step();
        one(3'b000, 32'd2, 32'd3);
        chk("post_rst_done", cur_done(), 1'b1);
        chk("post_rst_add", cur_res(), 32'd5);
        chk("post_rst_flags", cur_flags(), 4'b0000);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        sel8     = 1'b0;
        reset    = 1'b1;
        start32  = 1'b0;
        start8   = 1'b0;
        a_in     = '0;
        b_in     = '0;
        op_in    = '0;
        step();
        chk("reset_res", res32, 32'h0);
        chk("reset_flags", flags32, 4'h0);
        chk("reset_busy", busy32, 1'b0);
        chk("reset_done", done32, 1'b0);
        reset = 1'b0;
        step();

        // ---------------- WIDTH = 32 ----------------
        one(3'b000, 32'h7FFF_FFFF, 32'h0000_0001);
        chk("add_done", done32, 1'b1);
        chk("add_res", res32, 32'h8000_0000);
        chk("add_flags", flags32, 4'b1001);
        step();
        chk("add_done_pulse", done32, 1'b0);
        chk("add_hold", res32, 32'h8000_0000);

        go(3'b001, 32'd5, 32'd5);
        step();
        go(3'b011, 32'hF0, 32'h0F);
        chk("sub_done", done32, 1'b1);
        chk("sub_res", res32, 32'h0);
        chk("sub_flags", flags32, 4'b0110);
        step();
        start32 = 1'b0;
        chk("orr_done", done32, 1'b1);
        chk("orr_res", res32, 32'hFF);
        chk("orr_flags", flags32, 4'b0000);

        run_iter(3'b101, 32'h0001_0000, 32'h0001_0001, n);
        chk("mul_busy_cycles", n, 32);
        chk("mul_done", done32, 1'b1);
        chk("mul_res", res32, 32'h0001_0000);
        chk("mul_flags", flags32, 4'b0000);
        step();

        one(3'b110, 32'd100, 32'd7);
        n = 0;
        while (busy32 && n < 200) begin
            if (n == 4) go(3'b000, 32'd2, 32'd3);
            step();
            start32 = 1'b0;
            a_in    = 32'hDEAD_BEEF;
            b_in    = 32'h0000_0003;
            n++;
            if (n == 5) begin
                chk("udiv_ign_busy", busy32, 1'b1);
                chk("udiv_ign_done", done32, 1'b0);
                chk("udiv_ign_res", res32, 32'h0001_0000);
            end
        end
        chk("udiv_busy_cycles", n, 32);
        chk("udiv_done", done32, 1'b1);
        chk("udiv_res", res32, 32'd14);
        chk("udiv_flags", flags32, 4'b0000);
        step();
        chk("udiv_no_queue", done32, 1'b0);
        chk("udiv_hold", res32, 32'd14);

        run_iter(3'b111, 32'd100, 32'd7, n);
        chk("urem_res", res32, 32'd2);
        chk("urem_flags", flags32, 4'b0000);
        step();

        run_iter(3'b110, 32'h1234, 32'h0, n);
        chk("div0_busy_cycles", n, 32);
        chk("div0_done", done32, 1'b1);
        chk("div0_res", res32, 32'hFFFF_FFFF);
        chk("div0_flags", flags32, 4'b1001);
        // start presented in the done cycle must be accepted
        run_iter(3'b111, 32'h1234, 32'h0, n);
        chk("rem0_busy_cycles", n, 32);
        chk("rem0_res", res32, 32'h0000_1234);
        chk("rem0_flags", flags32, 4'b0001);
        step();

        reset_mid_mul(10, 32'h0001_0000, 32'h0001_0001);
        step();

        // ---------------- WIDTH = 8 ----------------
        sel8 = 1'b1;
        one(3'b000, 32'h7F, 32'h01);
        chk("w8_add_res", res8, 8'h80);
        chk("w8_add_flags", flags8, 4'b1001);
        step();

        run_iter(3'b101, 32'h10, 32'h11, n);
        chk("w8_mul_busy_cycles", n, 8);
        chk("w8_mul_done", done8, 1'b1);
        chk("w8_mul_res", res8, 8'h10);
        chk("w8_mul_flags", flags8, 4'b0000);
        step();

        run_iter(3'b110, 32'd100, 32'd7, n);
        chk("w8_udiv_busy_cycles", n, 8);
        chk("w8_udiv_res", res8, 8'd14);
        chk("w8_udiv_flags", flags8, 4'b0000);
        run_iter(3'b111, 32'd100, 32'd7, n);
        chk("w8_urem_res", res8, 8'd2);
        step();

        run_iter(3'b110, 32'h34, 32'h0, n);
        chk("w8_div0_busy_cycles", n, 8);
        chk("w8_div0_res", res8, 8'hFF);
        chk("w8_div0_flags", flags8, 4'b1001);
        run_iter(3'b111, 32'h34, 32'h0, n);
        chk("w8_rem0_res", res8, 8'h34);
        chk("w8_rem0_flags", flags8, 4'b0001);
        step();

        reset_mid_mul(4, 32'h10, 32'h11);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
